// File: rtl/instruction_fetch.sv
// IF stage: PC, instruction ROM and IF/ID register, with HALT detection; state updates on the falling clock edge.
// Optional macro IMEM_LOAD_EN adds a ROM load port that is writable during reset or HALTED.
module instruction_fetch #(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter string       INIT_FILE   = "program.hex",
    parameter logic [5:0]  HALT_OPCODE = 6'b111111,
    localparam int unsigned PC_W       = $clog2(MEM_DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clkEnable,
    input  logic            inHazard,
    input  logic            PCSrc,
    input  logic [PC_W-1:0] branchTarget,
    input  logic            jumpFlag,
    output logic [31:0]     Instruction,
    output logic [PC_W-1:0] PCCount,
    output logic [PC_W-1:0] pc,
    output logic            halted
`ifdef IMEM_LOAD_EN
    ,
    input  logic            loadWe,
    input  logic [PC_W-1:0] loadAddr,
    input  logic [31:0]     loadData
`endif
);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic [31:0]     rom [MEM_DEPTH];
    logic [0:0]      state;
    logic [0:0]      stateNext;
    logic [PC_W-1:0] pcNext;
    logic [31:0]     instrNext;
    logic [PC_W-1:0] pcCountNext;
    logic [31:0]     fetchWord;
    logic [PC_W-1:0] pcPlusOne;

`ifdef IMEM_LOAD_EN
    always_ff @(negedge clk) begin
        if (loadWe && (reset || state == HALTED)) rom[loadAddr] <= loadData;
    end
`endif

    assign fetchWord = rom[pc];
    assign pcPlusOne = pc + PC_W'(1);

    // Next-state selection: redirect beats stall beats jump beats halt beats normal fetch.
    always_comb begin
        pcNext      = pc;
        instrNext   = Instruction;
        pcCountNext = PCCount;
        stateNext   = state;
        if (PCSrc) begin
            pcNext      = branchTarget;
            instrNext   = NOP;
            pcCountNext = '0;
            stateNext   = RUN;
        end else if (inHazard) begin
            pcNext      = pc;
        end else if (jumpFlag) begin
            pcNext      = Instruction[PC_W-1:0];
            instrNext   = NOP;
            pcCountNext = '0;
        end else if (state == HALTED) begin
            instrNext   = NOP;
            pcCountNext = '0;
        end else begin
            instrNext   = fetchWord;
            pcCountNext = pcPlusOne;
            if (fetchWord[31:26] == HALT_OPCODE) begin
                stateNext = HALTED;
            end else begin
                pcNext    = pcPlusOne;
            end
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= '0;
            Instruction <= NOP;
            PCCount     <= '0;
            halted      <= 1'b0;
        end else if (clkEnable) begin
            state       <= stateNext;
            pc          <= pcNext;
            Instruction <= instrNext;
            PCCount     <= pcCountNext;
            halted      <= (stateNext == HALTED);
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected IF/ID contents are queued as each step is driven and checked after the edge.
module tb_instruction_fetch;

    logic        clk = 1'b1;
    logic        reset = 1'b1;
    logic        clkEnable = 1'b1;
    logic        inHazard = 1'b0;
    logic        PCSrc = 1'b0;
    logic [9:0]  branchTarget = 10'd0;
    logic        jumpFlag = 1'b0;
    logic [31:0] Instruction;
    logic [9:0]  PCCount;
    logic [9:0]  pc;
    logic        halted;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic [9:0]  cnt;
        logic [9:0]  pc;
        logic        h;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    instruction_fetch #(.MEM_DEPTH(1024), .INIT_FILE(""), .HALT_OPCODE(6'b111111)) dut (
        .clk(clk),
        .reset(reset),
        .clkEnable(clkEnable),
        .inHazard(inHazard),
        .PCSrc(PCSrc),
        .branchTarget(branchTarget),
        .jumpFlag(jumpFlag),
        .Instruction(Instruction),
        .PCCount(PCCount),
        .pc(pc),
        .halted(halted)
`ifdef IMEM_LOAD_EN
        ,
        .loadWe(1'b0),
        .loadAddr(10'd0),
        .loadData(32'h0)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romVal(int i);
        if (i == 7)  return 32'hFC00_0000;
        if (i == 41) return 32'h0800_0064;
        return 32'h2000_0000 | 32'(i);
    endfunction

    task automatic cmp(string tag, string field, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic push(string tag, logic [31:0] ins, logic [9:0] cnt, logic [9:0] p, logic h);
        exp_t e;
        e.tag = tag; e.instr = ins; e.cnt = cnt; e.pc = p; e.h = h;
        sb.push_back(e);
    endtask

    task automatic checkOne();
        exp_t e;
        e = sb.pop_front();
        cmp(e.tag, "Instruction", Instruction, e.instr);
        cmp(e.tag, "PCCount", 32'(PCCount), 32'(e.cnt));
        cmp(e.tag, "pc", 32'(pc), 32'(e.pc));
        cmp(e.tag, "halted", 32'(halted), 32'(e.h));
    endtask

    task automatic step(string tag, logic haz, logic src, logic jf, logic en, logic [9:0] bt,
                        logic [31:0] ins, logic [9:0] cnt, logic [9:0] p, logic h);
        inHazard = haz; PCSrc = src; jumpFlag = jf; clkEnable = en; branchTarget = bt;
        push(tag, ins, cnt, p, h);
        @(negedge clk);
        @(posedge clk);
        #1;
        checkOne();
    endtask

    task automatic norm(string tag, logic [31:0] ins, logic [9:0] cnt, logic [9:0] p, logic h);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, ins, cnt, p, h);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) dut.rom[i] = romVal(i);
        #2;
        push("reset", 32'h0, 10'd0, 10'd0, 1'b0);
        checkOne();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Sequential fetch from address 0
        norm("seq0", romVal(0), 10'd1, 10'd1, 1'b0);
        norm("seq1", romVal(1), 10'd2, 10'd2, 1'b0);
        norm("seq2", romVal(2), 10'd3, 10'd3, 1'b0);
        norm("seq3", romVal(3), 10'd4, 10'd4, 1'b0);
        norm("seq4", romVal(4), 10'd5, 10'd5, 1'b0);

        // Load-use stall holds everything
        step("haz0", 1'b1, 1'b0, 1'b0, 1'b1, 10'd0, romVal(4), 10'd5, 10'd5, 1'b0);
        step("haz1", 1'b1, 1'b0, 1'b0, 1'b1, 10'd0, romVal(4), 10'd5, 10'd5, 1'b0);
        norm("postHaz", romVal(5), 10'd6, 10'd6, 1'b0);

        // Branch overrides stall and jump together
        step("brAll", 1'b1, 1'b1, 1'b1, 1'b1, 10'd40, 32'h0, 10'd0, 10'd40, 1'b0);
        norm("br40", romVal(40), 10'd41, 10'd41, 1'b0);
        norm("fetchJ", romVal(41), 10'd42, 10'd42, 1'b0);

        // Jump squashes wrong-path fetch
        step("jump", 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 32'h0, 10'd0, 10'd100, 1'b0);
        norm("j100", romVal(100), 10'd101, 10'd101, 1'b0);

        // HALT fetch then branch out of HALTED
        step("br6", 1'b0, 1'b1, 1'b0, 1'b1, 10'd6, 32'h0, 10'd0, 10'd6, 1'b0);
        norm("pre7", romVal(6), 10'd7, 10'd7, 1'b0);
        norm("halt", 32'hFC00_0000, 10'd8, 10'd7, 1'b1);
        norm("halted0", 32'h0, 10'd0, 10'd7, 1'b1);
        norm("halted1", 32'h0, 10'd0, 10'd7, 1'b1);
        step("unhalt", 1'b0, 1'b1, 1'b0, 1'b1, 10'd2, 32'h0, 10'd0, 10'd2, 1'b0);
        norm("after2", romVal(2), 10'd3, 10'd3, 1'b0);

        // Async reset between edges while halted
        step("br7", 1'b0, 1'b1, 1'b0, 1'b1, 10'd7, 32'h0, 10'd0, 10'd7, 1'b0);
        norm("halt2", 32'hFC00_0000, 10'd8, 10'd7, 1'b1);
        norm("halted2", 32'h0, 10'd0, 10'd7, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        push("asyncRst", 32'h0, 10'd0, 10'd0, 1'b0);
        checkOne();
        reset = 1'b0;
        norm("rst0", romVal(0), 10'd1, 10'd1, 1'b0);

        // clkEnable low freezes all state
        step("dis0", 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, romVal(0), 10'd1, 10'd1, 1'b0);
        step("dis1", 1'b0, 1'b1, 1'b1, 1'b0, 10'd9, romVal(0), 10'd1, 10'd1, 1'b0);
        step("dis2", 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, romVal(0), 10'd1, 10'd1, 1'b0);
        norm("en", romVal(1), 10'd2, 10'd2, 1'b0);

        // PC wrap at the top of the ROM
        step("br1023", 1'b0, 1'b1, 1'b0, 1'b1, 10'd1023, 32'h0, 10'd0, 10'd1023, 1'b0);
        norm("wrap", romVal(1023), 10'd0, 10'd0, 1'b0);
        norm("afterWrap", romVal(0), 10'd1, 10'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
